spi_frame_engine: RTL and testbench

Byte-level SPI transceiver sitting directly below the SPI transaction sequencer. It accepts one-cycle frame commands (open frame, write byte, read byte, close frame) from the sequencer and drives the SPI pins, answering every accepted command with a one-cycle `o_done` pulse. The pins are SPI mode 0 (CPOL=0, CPHA=0), MSB first, with an active-high chip enable. The sequencer handles all command/result memory traffic; this block holds only one byte in each direction.

---
 rtl/spi_frame_engine_pkg.sv | 40 ++++
 rtl/spi_clk_div.sv | 36 +++
 rtl/spi_frame_engine.sv | 149 ++++++++++++++
 tb/tb_spi_frame_engine.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_frame_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module  : spi_frame_engine_pkg
// Brief   : Shared SPI frame-engine definitions: state encoding, frame width,
//           and the mode-0 / MSB-first wire conventions.
// Revision: 1.0  initial release
// ============================================================================
package spi_frame_engine_pkg;

    // Frame width in bits
    localparam int SPI_BITS = 8;

    // Mode 0: SCLK idles low, data captured on the edge leaving idle
    localparam logic SPI_CPOL      = 1'b0;
    localparam logic SPI_CPHA      = 1'b0;
    localparam logic SPI_MSB_FIRST = 1'b1;

    // Frame engine state encoding
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_OPEN  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_HOLD  = 3'd4,
        ST_GAP   = 3'd5
    } state_t;

    // Bit that goes on the wire next, given the current shift register
    function automatic logic spi_tx_bit(input logic [SPI_BITS-1:0] sh);
        return SPI_MSB_FIRST ? sh[SPI_BITS-1] : sh[0];
    endfunction

    // Shift register after consuming one transmitted bit and capturing one received bit
    function automatic logic [SPI_BITS-1:0] spi_shift_in(input logic [SPI_BITS-1:0] sh,
                                                         input logic              rx);
        return SPI_MSB_FIRST ? {sh[SPI_BITS-2:0], rx} : {rx, sh[SPI_BITS-1:1]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_clk_div.sv
`default_nettype none
// ============================================================================
// Module  : spi_clk_div
// Brief   : D-cycle tick generator with synchronous clear. Ticks on the last
//           cycle of every D-cycle window while not cleared.
// Revision: 1.0  initial release
// ============================================================================
module spi_clk_div #(
    parameter logic [15:0] DIVIDER = 16'd4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    output logic o_tick
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // Tick on the final count of the window; clear and wrap both return to 0
    always_comb begin
        o_tick = !i_clr && (cnt_q == DIVIDER - 16'd1);
        cnt_d  = (i_clr || o_tick) ? 16'd0 : cnt_q + 16'd1;
    end

    // Divider counter register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_frame_engine.sv
`default_nettype none
// ============================================================================
// Module  : spi_frame_engine
// Brief   : Byte-level SPI mode-0 transceiver. Executes open / write / read /
//           close frame commands and answers each accepted one with o_done.
// Revision: 1.0  initial release
// ============================================================================
module spi_frame_engine
    import spi_frame_engine_pkg::*;
#(
    parameter logic [15:0] CLK_DIVIDER = 16'd4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_stop,
    input  logic       i_write,
    input  logic       i_read,
    output logic       o_done,
    input  logic [7:0] i_mosi_data,
    output logic [7:0] o_miso_data,
    output logic       o_spi_en,
    output logic       o_spi_mosi,
    input  logic       i_spi_miso,
    output logic       o_spi_clk
);

    localparam logic [2:0] LAST_BIT = 3'(SPI_BITS - 1);
    // Capture on the edge that leaves the idle level when CPHA is 0
    localparam logic CAPTURE_ON_LEAD = !SPI_CPHA;

    state_t      state_q;
    logic        spi_en_q;
    logic        spi_clk_q;
    logic        spi_mosi_q;
    logic        done_q;
    logic        is_read_q;
    logic [7:0]  shreg_q;
    logic [7:0]  miso_data_q;
    logic [2:0]  bit_cnt_q;

    logic        w_tick;
    logic        w_div_clr;
    logic        w_capture;

    // Divider only runs in the timed states, so it always starts a state at 0
    assign w_div_clr = (state_q == ST_IDLE) || (state_q == ST_OPEN);
    // This SCLK toggle is the capture edge when it leaves the idle level
    assign w_capture = ((spi_clk_q == SPI_CPOL) == CAPTURE_ON_LEAD);

    spi_clk_div #(
        .DIVIDER (CLK_DIVIDER)
    ) u_clk_div (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (w_div_clr),
        .o_tick (w_tick)
    );

    // Frame FSM with all pin and handshake outputs registered
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            spi_en_q    <= 1'b0;
            spi_clk_q   <= SPI_CPOL;
            spi_mosi_q  <= 1'b0;
            done_q      <= 1'b0;
            is_read_q   <= 1'b0;
            shreg_q     <= 8'h00;
            miso_data_q <= 8'h00;
            bit_cnt_q   <= 3'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // Only start is legal here; anything else is dropped
                    if (i_start) begin
                        state_q  <= ST_SETUP;
                        spi_en_q <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    if (w_tick) begin
                        state_q <= ST_OPEN;
                        done_q  <= 1'b1;
                    end
                end
                ST_OPEN: begin
                    // Stop outranks write, which outranks read
                    if (i_stop) begin
                        state_q <= ST_HOLD;
                    end else if (i_write) begin
                        state_q    <= ST_SHIFT;
                        shreg_q    <= i_mosi_data;
                        spi_mosi_q <= spi_tx_bit(i_mosi_data);
                        is_read_q  <= 1'b0;
                    end else if (i_read) begin
                        state_q    <= ST_SHIFT;
                        shreg_q    <= 8'h00;
                        spi_mosi_q <= 1'b0;
                        is_read_q  <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (w_tick) begin
                        spi_clk_q <= ~spi_clk_q;
                        if (w_capture) begin
                            shreg_q <= spi_shift_in(shreg_q, i_spi_miso);
                        end else if (bit_cnt_q == LAST_BIT) begin
                            // Last falling edge: byte complete, back to OPEN
                            state_q     <= ST_OPEN;
                            spi_mosi_q  <= 1'b0;
                            done_q      <= 1'b1;
                            miso_data_q <= shreg_q;
                            bit_cnt_q   <= 3'd0;
                        end else begin
                            // Falling edge: present the next bit while SCLK is low
                            bit_cnt_q  <= bit_cnt_q + 3'd1;
                            spi_mosi_q <= is_read_q ? 1'b0 : spi_tx_bit(shreg_q);
                        end
                    end
                end
                ST_HOLD: begin
                    if (w_tick) begin
                        state_q  <= ST_GAP;
                        spi_en_q <= 1'b0;
                    end
                end
                ST_GAP: begin
                    if (w_tick) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_done      = done_q;
    assign o_miso_data = miso_data_q;
    assign o_spi_en    = spi_en_q;
    assign o_spi_mosi  = spi_mosi_q;
    assign o_spi_clk   = spi_clk_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_frame_engine.sv
`default_nettype none
// ============================================================================
// Module  : tb_spi_frame_engine
// Brief   : Self-checking bench for spi_frame_engine at D=4 and D=1 against a
//           transaction-level model of command latency and byte exchange.
// Revision: 1.0  initial release
// ============================================================================
module tb_spi_frame_engine;

    localparam int K_START = 0;
    localparam int K_STOP  = 1;
    localparam int K_WRITE = 2;
    localparam int K_READ  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst   = 1'b1;
    logic       start = 1'b0;
    logic       stop  = 1'b0;
    logic       wr    = 1'b0;
    logic       rd    = 1'b0;
    logic       miso  = 1'b0;
    logic [7:0] mdata = 8'h00;

    logic       done4, en4, mosi4, sclk4;
    logic [7:0] rx4;
    logic       done1, en1, mosi1, sclk1;
    logic [7:0] rx1;

    spi_frame_engine #(.CLK_DIVIDER(16'd4)) u_dut4 (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop),
        .i_write(wr), .i_read(rd), .o_done(done4), .i_mosi_data(mdata),
        .o_miso_data(rx4), .o_spi_en(en4), .o_spi_mosi(mosi4),
        .i_spi_miso(miso), .o_spi_clk(sclk4)
    );

    spi_frame_engine #(.CLK_DIVIDER(16'd1)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop),
        .i_write(wr), .i_read(rd), .o_done(done1), .i_mosi_data(mdata),
        .o_miso_data(rx1), .o_spi_en(en1), .o_spi_mosi(mosi1),
        .i_spi_miso(miso), .o_spi_clk(sclk1)
    );

    // Observed instance selection
    int         sel = 0;
    logic       o_done, o_en, o_mosi, o_sclk;
    logic [7:0] o_rx;
    assign o_done = (sel != 0) ? done1 : done4;
    assign o_en   = (sel != 0) ? en1   : en4;
    assign o_mosi = (sel != 0) ? mosi1 : mosi4;
    assign o_sclk = (sel != 0) ? sclk1 : sclk4;
    assign o_rx   = (sel != 0) ? rx1   : rx4;

    int checks = 0;
    int fails  = 0;

    // Monitor state
    int         rises = 0, total_rises = 0, toggles = 0, dones = 0;
    bit         prev_sclk = 1'b0, mosi_hi = 1'b0, en_hi = 1'b0;
    logic [7:0] mosi_cap = 8'h00, slave_byte = 8'h00;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference model: cycles from command sample to o_done
    function automatic int exp_latency(input int kind, input int d);
        case (kind)
            K_START: return 1 + d;
            K_STOP:  return 1 + 2 * d;
            default: return 1 + 2 * d * 8;
        endcase
    endfunction

    // Advance one clock and observe pins; acts as the mode-0 slave
    task automatic step();
        @(posedge clk);
        #1;
        if (o_sclk !== prev_sclk) toggles++;
        if (o_sclk && !prev_sclk) begin
            mosi_cap = {mosi_cap[6:0], o_mosi};
            rises++;
            total_rises++;
            if (rises < 8) miso = slave_byte[3'(7 - rises)];
            else           miso = 1'b0;
        end
        prev_sclk = o_sclk;
        if (o_mosi) mosi_hi = 1'b1;
        if (o_en)   en_hi   = 1'b1;
        if (o_done) dones++;
    endtask

    task automatic clear_mon();
        rises = 0; toggles = 0; dones = 0;
        mosi_hi = 1'b0; en_hi = 1'b0; mosi_cap = 8'h00;
    endtask

    task automatic do_reset();
        start = 0; stop = 0; wr = 0; rd = 0;
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        step();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " en"},   32'(o_en),   32'd0);
        check({tag, " sclk"}, 32'(o_sclk), 32'd0);
        check({tag, " mosi"}, 32'(o_mosi), 32'd0);
        check({tag, " done"}, 32'(o_done), 32'd0);
        check({tag, " rx"},   32'(o_rx),   32'h00);
    endtask

    // Issue one command in the current cycle and check it against the model
    task automatic run_cmd(input string tag, input int kind, input logic [7:0] wdata,
                           input logic [7:0] sbyte, input bit also_write);
        int d, exp_n, n;
        logic e_1, e_d, e_d1;
        d     = (sel != 0) ? 1 : 4;
        exp_n = exp_latency(kind, d);
        clear_mon();
        slave_byte = sbyte;
        miso  = sbyte[7];
        start = (kind == K_START);
        stop  = (kind == K_STOP);
        wr    = (kind == K_WRITE) || also_write;
        rd    = (kind == K_READ);
        mdata = wdata;
        step();
        start = 0; stop = 0; wr = 0; rd = 0;
        mdata = 8'($urandom);
        n = 1;
        e_1 = o_en; e_d = o_en; e_d1 = o_en;
        while (dones == 0 && n < exp_n + 20) begin
            if (n == d)     e_d  = o_en;
            if (n == d + 1) e_d1 = o_en;
            step();
            n++;
        end
        check({tag, " latency"}, 32'(n), 32'(exp_n));
        check({tag, " done count"}, 32'(dones), 32'd1);
        case (kind)
            K_START: begin
                check({tag, " en at T+1"}, 32'(e_1), 32'd1);
                check({tag, " sclk idle"}, 32'(toggles), 32'd0);
            end
            K_STOP: begin
                check({tag, " en before fall"}, 32'(e_d), 32'd1);
                check({tag, " en fall"}, 32'(e_d1), 32'd0);
                check({tag, " sclk idle"}, 32'(toggles), 32'd0);
            end
            K_WRITE: begin
                check({tag, " rises"}, 32'(rises), 32'd8);
                check({tag, " mosi byte"}, 32'(mosi_cap), 32'(wdata));
                check({tag, " rx byte"}, 32'(o_rx), 32'(sbyte));
            end
            default: begin
                check({tag, " rises"}, 32'(rises), 32'd8);
                check({tag, " mosi held 0"}, 32'(mosi_hi), 32'd0);
                check({tag, " rx byte"}, 32'(o_rx), 32'(sbyte));
            end
        endcase
    endtask

    // Reset in the middle of a write, then a full clean frame
    task automatic abort_test(input string tag);
        int n;
        run_cmd({tag, " start"}, K_START, 8'h00, 8'h00, 1'b0);
        clear_mon();
        slave_byte = 8'($urandom);
        miso  = slave_byte[7];
        wr    = 1'b1;
        mdata = 8'hC3;
        step();
        wr = 1'b0;
        n  = 0;
        while (rises < 3 && n < 200) begin
            step();
            n++;
        end
        check({tag, " reached bit3"}, 32'(rises), 32'd3);
        rst = 1'b1;
        step();
        check_reset_vals({tag, " mid-byte"});
        rst = 1'b0;
        clear_mon();
        repeat (40) step();
        check({tag, " no late done"}, 32'(dones), 32'd0);
        check({tag, " pins quiet"}, 32'(toggles + 32'(en_hi) + 32'(mosi_hi)), 32'd0);
        run_cmd({tag, " restart"}, K_START, 8'h00, 8'h00, 1'b0);
        run_cmd({tag, " write 5A"}, K_WRITE, 8'h5A, 8'($urandom), 1'b0);
        run_cmd({tag, " stop"}, K_STOP, 8'h00, 8'h00, 1'b0);
    endtask

    // Random sequence of writes and reads inside one frame
    task automatic random_frame(input string tag, input int count);
        run_cmd({tag, " start"}, K_START, 8'h00, 8'h00, 1'b0);
        for (int i = 0; i < count; i++) begin
            if ($urandom_range(0, 1) == 0)
                run_cmd($sformatf("%s wr%0d", tag, i), K_WRITE, 8'($urandom), 8'($urandom), 1'b0);
            else
                run_cmd($sformatf("%s rd%0d", tag, i), K_READ, 8'($urandom), 8'($urandom), 1'b0);
        end
        run_cmd({tag, " stop"}, K_STOP, 8'h00, 8'h00, 1'b0);
    endtask

    initial begin
        // ---------------- D = 4 ----------------
        sel = 0;
        do_reset();
        check_reset_vals("D4 reset");

        run_cmd("D4 open", K_START, 8'h00, 8'h00, 1'b0);
        run_cmd("D4 close", K_STOP, 8'h00, 8'h00, 1'b0);

        run_cmd("D4 start", K_START, 8'h00, 8'h00, 1'b0);
        run_cmd("D4 write A5", K_WRITE, 8'hA5, 8'($urandom), 1'b0);
        run_cmd("D4 read 3C", K_READ, 8'hFF, 8'h3C, 1'b0);

        // Back-to-back commands issued in the o_done cycle
        total_rises = 0;
        run_cmd("D4 b2b write 01", K_WRITE, 8'h01, 8'h00, 1'b0);
        run_cmd("D4 b2b read FF", K_READ, 8'h00, 8'hFF, 1'b0);
        check("D4 b2b total rises", 32'(total_rises), 32'd16);
        run_cmd("D4 stop", K_STOP, 8'h00, 8'h00, 1'b0);

        // Write while no frame is open must be ignored
        repeat (3) step();
        clear_mon();
        wr = 1'b1; mdata = 8'hFF;
        step();
        wr = 1'b0;
        repeat (40) step();
        check("D4 idle write done", 32'(dones), 32'd0);
        check("D4 idle write sclk", 32'(toggles), 32'd0);
        check("D4 idle write en", 32'(en_hi), 32'd0);
        check("D4 idle write mosi", 32'(mosi_hi), 32'd0);

        // Start and write together: start only
        run_cmd("D4 start+write", K_START, 8'hFF, 8'h00, 1'b1);
        run_cmd("D4 after combo write", K_WRITE, 8'h96, 8'h69, 1'b0);
        run_cmd("D4 combo stop", K_STOP, 8'h00, 8'h00, 1'b0);

        random_frame("D4 rand", 6);
        abort_test("D4 abort");

        // ---------------- D = 1 ----------------
        sel = 1;
        do_reset();
        check_reset_vals("D1 reset");
        random_frame("D1 rand", 6);
        abort_test("D1 abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
